button_event_decoder: RTL and testbench

//  Consumes the debounced push-button level (1 = held) and turns it into one-cycle

---
 rtl/button_event_decoder.sv | 177 +++++++++++++++++
 tb/tb_button_event_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Purpose : turns the debounced push-button level into one-cycle press/release/short/long/repeat strobes
//           and reports the hold duration in timer ticks.
// Latency : every output is registered; a strobe appears the cycle after the clock edge that detects its condition.
// Backpressure: none; strobes are fire-and-forget.
// Optional feature: define AUTOREPEAT_EN to enable repeat_pulse while long-held; otherwise repeat_pulse is 0.
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         synchronous reset, active low
//   pb_state      debounced button level, 1 = held
//   press_pulse   strobe on a press edge
//   release_pulse strobe on every release edge
//   short_press   strobe on release before LONG_TICKS
//   long_press    strobe when hold reaches LONG_TICKS
//   repeat_pulse  strobe every REPEAT_TICKS while long-held
//   held_ticks    ticks held in current/last press, saturating
module button_event_decoder #(
    parameter int CLK          = 50000000,
    parameter int TICK_HZ      = 1000,
    parameter int LONG_TICKS   = 800,
    parameter int REPEAT_TICKS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pb_state,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        short_press,
    output logic        long_press,
    output logic        repeat_pulse,
    output logic [15:0] held_ticks
);

    localparam int DIV = CLK / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    // Elaboration-time guard against unusable parameter sets.
    if ((DIV < 2) || (LONG_TICKS < 1) || (LONG_TICKS > 65535) || (REPEAT_TICKS < 1)) begin : g_param_check
        $error("button_event_decoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_pb_q;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_held;
    logic [15:0]   w_held_nxt;
    logic [15:0]   w_held_inc;
    logic          r_press, r_release, r_short, r_long;
    logic          w_press_nxt, w_release_nxt, w_short_nxt, w_long_nxt;
    logic          w_rise, w_fall, w_tick;

    assign w_rise     = pb_state & ~r_pb_q;
    assign w_fall     = ~pb_state & r_pb_q;
    assign w_tick     = (r_presc == PW'(DIV - 1));
    assign w_held_inc = r_held + 16'd1;

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_nxt;
    logic [RW-1:0] w_rep_inc;
    logic          r_repeat;
    logic          w_repeat_nxt;

    assign w_rep_inc    = r_rep_cnt + RW'(1);
    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_held_nxt    = r_held;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
`ifdef AUTOREPEAT_EN
        w_rep_nxt     = r_rep_cnt;
        w_repeat_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_held_nxt  = 16'd0;
`ifdef AUTOREPEAT_EN
                    w_rep_nxt   = '0;
`endif
                    w_state_nxt = S_PRESSED;
                end
            end
            S_PRESSED: begin
                // A release on the same edge as a tick wins: the press stays short.
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_short_nxt   = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (w_tick) begin
                    w_held_nxt = w_held_inc;
                    if (w_held_inc == 16'(LONG_TICKS)) begin
                        w_long_nxt  = 1'b1;
                        w_state_nxt = S_LONG;
                    end
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (w_tick) begin
                    if (r_held != 16'hFFFF) begin
                        w_held_nxt = w_held_inc;
                    end
`ifdef AUTOREPEAT_EN
                    if (w_rep_inc == RW'(REPEAT_TICKS)) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt    = w_rep_inc;
                    end
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            // Treat the button as already held so a press held through reset is ignored.
            r_pb_q    <= 1'b1;
            r_presc   <= '0;
            r_held    <= 16'd0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
`ifdef AUTOREPEAT_EN
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pb_q    <= pb_state;
            // Restart the tick timer on a press so the first tick is a full period later.
            if (w_rise || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_held    <= w_held_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_short   <= w_short_nxt;
            r_long    <= w_long_nxt;
`ifdef AUTOREPEAT_EN
            r_rep_cnt <= w_rep_nxt;
            r_repeat  <= w_repeat_nxt;
`endif
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_press   = r_short;
    assign long_press    = r_long;
    assign held_ticks    = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Purpose : randomized bench for button_event_decoder with an event-schedule reference model.
// Latency : expected strobes are scheduled by edge number and matched when the DUT raises any strobe.
// Backpressure: none.
module tb_button_event_decoder;

    localparam int CLK_HZ = 1000;
    localparam int TICK   = 100;
    localparam int LONG   = 5;
    localparam int REP    = 2;
    localparam int DIV    = CLK_HZ / TICK;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        pb_state = 1'b1;
    logic        press_pulse, release_pulse, short_press, long_press, repeat_pulse;
    logic [15:0] held_ticks;

    int cyc       = 0;
    int n_chk     = 0;
    int n_fail    = 0;
    int last_held = 0;

    typedef struct {
        int          edge_no;
        logic [4:0]  vec;   // {press, release, short, long, repeat}
        logic [15:0] held;
    } ev_t;

    ev_t exp_q[$];

    button_event_decoder #(
        .CLK          (CLK_HZ),
        .TICK_HZ      (TICK),
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REP)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_state      (pb_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held_ticks    (held_ticks)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; at a negedge it names the edge whose results are visible.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] strobes();
        return {press_pulse, release_pulse, short_press, long_press, repeat_pulse};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int e, input logic [4:0] v, input int h);
        ev_t ev;
        ev.edge_no = e;
        ev.vec     = v;
        ev.held    = 16'(h);
        exp_q.push_back(ev);
    endfunction

    // Reference model: a press first sampled at edge r, held h cycles, released at edge r+h.
    // Ticks land on edges r+k*DIV; a tick on the release edge does not count.
    // A reset at edge x discards every event from x onward.
    function automatic void plan(input int r, input int h, input int x);
        int n;
        n = (h - 1) / DIV;
        if (r < x) push(r, 5'b10000, 0);
        if (n >= LONG) begin
            if (r + LONG * DIV < x) push(r + LONG * DIV, 5'b00010, LONG);
`ifdef AUTOREPEAT_EN
            for (int t = LONG + REP; t <= n; t += REP) begin
                if (r + t * DIV < x) push(r + t * DIV, 5'b00001, t);
            end
`endif
            if (r + h < x) push(r + h, 5'b01000, n);
        end else begin
            if (r + h < x) push(r + h, 5'b01100, n);
        end
        last_held = (x < r + h) ? 0 : n;
    endfunction

    // Monitor: whenever any strobe is up, it must be the next scheduled event.
    always @(negedge clk) begin : mon
        logic [4:0] v;
        ev_t        e;
        v = strobes();
        if (v != 5'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", int'(v), 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_edge", cyc, e.edge_no);
                chk("strobe_vec", int'(v), int'(e.vec));
                chk("held_at_strobe", int'(held_ticks), int'(e.held));
            end
        end
    end

    task automatic idle(input int n);
        pb_state = 1'b0;
        repeat (n) @(negedge clk);
        chk("held_in_idle", int'(held_ticks), last_held);
    endtask

    // Called at a negedge with the button released and the DUT idle.
    task automatic press(input int h, input int rst_at);
        int r;
        r = cyc + 1;
        plan(r, h, (rst_at >= 0) ? r + rst_at : 32'h7fffffff);
        pb_state = 1'b1;
        for (int i = 0; i < h; i++) begin
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (i == rst_at) begin
                chk("midpress_reset_strobes", int'(strobes()), 0);
                chk("midpress_reset_held", int'(held_ticks), 0);
            end
        end
        rst_n    = 1'b1;
        pb_state = 1'b0;
    endtask

    initial begin
        int h;
        int ra;
        // Button held through reset and afterwards: never a press.
        rst_n    = 1'b0;
        pb_state = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_strobes", int'(strobes()), 0);
        chk("reset_held", int'(held_ticks), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_through_reset", int'(held_ticks), 0);
        last_held = 0;
        idle(5);

        press(25, -1);  idle(5);   // short press, 2 ticks
        press(50, -1);  idle(5);   // release on the 5th tick edge: short, 4 ticks
        press(95, -1);  idle(5);   // long press with repeats at ticks 7 and 9
        press(1, -1);   idle(3);   // one-cycle press
        press(60, 30);  idle(5);   // reset mid-press
        press(15, -1);  idle(5);   // next real press after the reset

        for (int k = 0; k < 40; k++) begin
            h  = int'($urandom_range(120, 1));
            ra = ($urandom_range(7, 0) == 0) ? int'($urandom_range(h - 1, 0)) : -1;
            press(h, ra);
            idle(int'($urandom_range(12, 1)));
        end

        repeat (5) @(negedge clk);
        chk("events_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
